// File: rtl/xor_checksum_pkg.sv
// Shared definitions for the streaming XOR checksum: FSM state encoding and
// the count-width helper.
package xor_checksum_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    // Width needed to hold the values 0..max_words inclusive.
    function automatic int calc_cw(input int max_words);
        return (max_words < 1) ? 1 : $clog2(max_words + 1);
    endfunction

endpackage : xor_checksum_pkg

// File: rtl/xor_checksum_xor_n.sv
// WIDTH-bit bitwise XOR of two vectors, built bit by bit from xor_gate instances.
module xor_n #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xor_gate u_gate (
            .a (a[i]),
            .b (b[i]),
            .y (y[i])
        );
    end

endmodule : xor_n

// File: rtl/xor_gate.sv
// Two-input XOR gate, the combinational building block of the checksum datapath.
module xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule : xor_gate

// File: rtl/xor_checksum.sv
// Streaming XOR checksum: folds a framed word stream into a running XOR and
// presents checksum, word count, parity and over-length flag per frame.
module xor_checksum
    import xor_checksum_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               MAX_WORDS = 256,
    parameter logic [WIDTH-1:0] SEED      = '0,
    localparam int              CW        = calc_cw(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CW-1:0]    out_count,
    output logic             out_parity,
    output logic             out_err
);

    localparam logic [CW-1:0] LAST_IDX = CW'(MAX_WORDS - 1);

    state_t           state_q, state_next;
    logic [WIDTH-1:0] sum_q, sum_next;
    logic [CW-1:0]    count_q, count_inc;
    logic [WIDTH-1:0] out_sum_q;
    logic [CW-1:0]    out_count_q;
    logic             out_err_q;
    logic             accept, close, handoff, at_limit;

    xor_n #(.WIDTH(WIDTH)) u_fold (
        .a (sum_q),
        .b (in_data),
        .y (sum_next)
    );

    assign count_inc = count_q + CW'(1);
    assign at_limit  = (count_q == LAST_IDX);

    // Handshake outputs decode the state register only, so no input reaches them combinationally.
    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_HOLD);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_next = state_q;
        accept     = 1'b0;
        close      = 1'b0;
        handoff    = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                accept = in_valid;
                close  = in_valid && (in_last || at_limit);
                if (close) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                handoff = out_ready;
                if (handoff) state_next = ST_ACCUM;
            end
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            sum_q       <= SEED;
            count_q     <= '0;
            out_sum_q   <= SEED;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q <= state_next;
            if (accept) begin
                sum_q   <= sum_next;
                count_q <= count_inc;
            end
            if (close) begin
                out_sum_q   <= sum_next;
                out_count_q <= count_inc;
                out_err_q   <= !in_last;
            end
            if (handoff) begin
                sum_q   <= SEED;
                count_q <= '0;
            end
        end
    end

    assign out_sum    = out_sum_q;
    assign out_count  = out_count_q;
    assign out_err    = out_err_q;
    assign out_parity = ^out_sum_q;

endmodule : xor_checksum

// File: tb/tb_xor_checksum.sv
// Self-checking bench: two instances (SEED=0x00 and SEED=0xFF) share one
// stimulus stream; a behavioural model fills per-instance result queues.
module tb_xor_checksum;

    localparam int        W    = 8;
    localparam int        MAXW = 4;
    localparam int        CWB  = 3;
    localparam logic [7:0] SEED0 = 8'h00;
    localparam logic [7:0] SEED1 = 8'hFF;

    typedef struct packed {
        logic [W-1:0]   sum;
        logic [CWB-1:0] count;
        logic           err;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_last, out_ready;
    logic [W-1:0]   in_data;
    logic           in_ready0, out_valid0, out_parity0, out_err0;
    logic           in_ready1, out_valid1, out_parity1, out_err1;
    logic [W-1:0]   out_sum0, out_sum1;
    logic [CWB-1:0] out_count0, out_count1;

    int checks = 0;
    int errors = 0;

    exp_t         q0[$];
    exp_t         q1[$];
    logic [W-1:0] m_sum0, m_sum1;
    int           m_count;

    always #5 clk = ~clk;

    xor_checksum #(.WIDTH(W), .MAX_WORDS(MAXW), .SEED(SEED0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_sum(out_sum0), .out_count(out_count0), .out_parity(out_parity0), .out_err(out_err0)
    );

    xor_checksum #(.WIDTH(W), .MAX_WORDS(MAXW), .SEED(SEED1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_sum(out_sum1), .out_count(out_count1), .out_parity(out_parity1), .out_err(out_err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_sum0  = SEED0;
        m_sum1  = SEED1;
        m_count = 0;
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) step();
        rst_n = 1'b1;
        model_clear();
    endtask

    // Drives one accepted beat and updates the model; pushes the expected result on frame close.
    task automatic beat(input logic [W-1:0] data, input logic last);
        check("in_ready_before_beat0", in_ready0, 1);
        check("in_ready_before_beat1", in_ready1, 1);
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_sum0  = m_sum0 ^ data;
        m_sum1  = m_sum1 ^ data;
        m_count = m_count + 1;
        if (last || m_count == MAXW) begin
            q0.push_back('{sum: m_sum0, count: CWB'(m_count), err: !last});
            q1.push_back('{sum: m_sum1, count: CWB'(m_count), err: !last});
            model_clear();
        end
    endtask

    task automatic compare_head();
        exp_t e0, e1;
        if (q0.size() == 0 || q1.size() == 0) begin
            check("unexpected_output", out_valid0, 0);
            return;
        end
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        check("sum0",    out_sum0,    e0.sum);
        check("count0",  out_count0,  e0.count);
        check("parity0", out_parity0, ^e0.sum);
        check("err0",    out_err0,    e0.err);
        check("sum1",    out_sum1,    e1.sum);
        check("count1",  out_count1,  e1.count);
        check("parity1", out_parity1, ^e1.sum);
        check("err1",    out_err1,    e1.err);
    endtask

    // Waits (bounded) for a result, compares it against the queue head, then accepts it.
    task automatic collect();
        int n = 0;
        while (!out_valid0 && n < 20) begin
            step();
            n++;
        end
        check("out_valid0_seen", out_valid0, 1);
        check("out_valid1_seen", out_valid1, 1);
        check("in_ready0_hold",  in_ready0,  0);
        compare_head();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("out_valid0_drop", out_valid0, 0);
        check("in_ready0_back",  in_ready0,  1);
        check("in_ready1_back",  in_ready1,  1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        model_clear();

        do_reset(2);
        check("rst_in_ready",   in_ready0,   1);
        check("rst_out_valid",  out_valid0,  0);
        check("rst_sum0",       out_sum0,    8'h00);
        check("rst_count0",     out_count0,  0);
        check("rst_parity0",    out_parity0, 0);
        check("rst_err0",       out_err0,    0);
        check("rst_sum1",       out_sum1,    8'hFF);
        check("rst_parity1",    out_parity1, 0);

        // Frame A5, 3C, idle, FF (last): expect 0x66 / count 3.
        beat(8'hA5, 1'b0);
        beat(8'h3C, 1'b0);
        step();
        beat(8'hFF, 1'b1);
        check("frame_a_sum_literal", out_sum0, 8'h66);
        collect();

        // Backpressure with a competing word that must be ignored.
        beat(8'h80, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_out_valid", out_valid0,  1);
            check("bp_in_ready",  in_ready0,   0);
            check("bp_sum",       out_sum0,    8'h80);
            check("bp_count",     out_count0,  1);
            check("bp_parity",    out_parity0, 1);
        end
        in_valid = 1'b0;
        collect();
        check("after_release_keep_sum", out_sum0, 8'h80);
        beat(8'h55, 1'b1);
        collect();

        // Over-length forced close, then the same words closed exactly at the limit.
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h04, 1'b0);
        beat(8'h08, 1'b0);
        check("ovl_err_literal", out_err0, 1);
        collect();
        beat(8'h01, 1'b0);
        beat(8'h02, 1'b0);
        beat(8'h04, 1'b0);
        beat(8'h08, 1'b1);
        check("lim_err_literal", out_err0, 0);
        collect();

        // Reset mid-frame discards the partial frame.
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        do_reset(1);
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_sum0",      out_sum0,   8'h00);
        check("midrst_sum1",      out_sum1,   8'hFF);
        beat(8'h33, 1'b1);
        check("midrst_frame_literal", out_sum0, 8'h33);
        collect();

        // Seed reload across consecutive frames (SEED=0xFF instance: F0 then FF).
        beat(8'h0F, 1'b1);
        check("seed_f0_literal", out_sum1, 8'hF0);
        collect();
        beat(8'h00, 1'b1);
        check("seed_ff_literal", out_sum1, 8'hFF);
        collect();

        // A few random frames of random length through the scoreboard.
        for (int f = 0; f < 6; f++) begin
            int len = $urandom_range(1, MAXW + 1);
            for (int k = 0; k < len; k++) begin
                beat(W'($urandom), (k == len - 1));
                if (m_count == 0) break;
            end
            collect();
        end

        check("queue0_empty", q0.size(), 0);
        check("queue1_empty", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_xor_checksum
